cmp_flags_gen: RTL and testbench

CMP_FLAGS_GEN -- requirements
Module: cmp_flags_gen

---
 rtl/cmp_flags_gen.sv | 105 ++++++++++
 tb/tb_cmp_flags_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cmp_flags_gen.sv
// Multi-cycle magnitude comparator: walks the operands one CHUNK slice per cycle,
// MSB slice first, stopping at the first differing slice to report eq/gt/lt flags.
module cmp_flags_gen #(
  parameter int W     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sgn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [1:0]   flags
);

  localparam int NCH = W / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] FL_EQ = 2'b00;
  localparam logic [1:0] FL_GT = 2'b01;
  localparam logic [1:0] FL_LT = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [IW-1:0]    r_idx;
  logic [1:0]       r_flags;
  logic [CHUNK-1:0] w_sl_a;
  logic [CHUNK-1:0] w_sl_b;
  logic             w_gt;
  logic             w_lt;

  // Slice mux built from constant part-selects so every select stays in range.
  always_comb begin
    w_sl_a = '0;
    w_sl_b = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_idx == IW'(i)) begin
        w_sl_a = r_a[i*CHUNK +: CHUNK];
        w_sl_b = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  assign w_gt = (w_sl_a > w_sl_b);
  assign w_lt = (w_sl_a < w_sl_b);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CMP;
      CMP:     if (w_gt || w_lt || (r_idx == '0)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_flags <= FL_EQ;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (start) begin
            // Flipping the sign bits maps two's-complement order onto unsigned order.
            r_a   <= {a[W-1] ^ sgn, a[W-2:0]};
            r_b   <= {b[W-1] ^ sgn, b[W-2:0]};
            r_idx <= IW'(NCH - 1);
          end
        end
        CMP: begin
          if (w_gt) begin
            r_flags <= FL_GT;
          end else if (w_lt) begin
            r_flags <= FL_LT;
          end else if (r_idx == '0) begin
            r_flags <= FL_EQ;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state == CMP);
  assign done  = (r_state == DONE);
  assign flags = r_flags;

endmodule

// File: tb/tb_cmp_flags_gen.sv
// Randomized and directed bench for cmp_flags_gen against a cycle-level
// reference built from plain signed/unsigned arithmetic and a slice countdown.
module tb_cmp_flags_gen;

  localparam int W     = 32;
  localparam int CHUNK = 8;
  localparam int NCH   = W / CHUNK;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sgn;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [1:0]   flags;

  int n_chk;
  int n_pass;

  int         m_rem;
  bit         m_done;
  logic [1:0] m_flags;
  logic [1:0] m_pend;

  cmp_flags_gen #(.W(W), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .flags (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [1:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
    if (s) begin
      if ($signed(x) > $signed(y)) return 2'b01;
      if ($signed(x) < $signed(y)) return 2'b10;
    end else begin
      if (x > y) return 2'b01;
      if (x < y) return 2'b10;
    end
    return 2'b00;
  endfunction

  // Number of slices examined: up to and including the first differing one from the top.
  function automatic int ref_k(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = NCH - 1; i >= 0; i--)
      if (x[i*CHUNK +: CHUNK] != y[i*CHUNK +: CHUNK]) return NCH - i;
    return NCH;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_rem = 0; m_done = 0; m_flags = 2'b00;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_done  = 1;
        m_flags = m_pend;
      end
    end else if (start) begin
      m_rem  = ref_k(a, b);
      m_pend = ref_flags(a, b, sgn);
    end
    #1;
    chk("busy", busy, m_rem > 0);
    chk("done", done, m_done);
    chk("flags", flags, m_flags);
    chk("flags_not_11", flags == 2'b11, 1'b0);
  endtask

  task automatic run(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isgn,
                     input int exp_k, input logic [1:0] exp_fl, input bit junk,
                     input string nm);
    int e;
    int bcnt;
    bit seen;
    a = ia; b = ib; sgn = isgn; start = 1'b1;
    tick();
    e = 0; bcnt = 0; seen = 0;
    if (!junk) start = 1'b0;
    while (!seen && e < 12) begin
      if (junk) begin
        a = $urandom; b = $urandom; sgn = 1'($urandom_range(0, 1));
      end
      if (busy) bcnt++;
      if (done) seen = 1;
      else begin
        tick();
        e++;
      end
    end
    chk({nm, ".done_seen"}, seen, 1'b1);
    chk({nm, ".busy_cycles"}, bcnt, exp_k);
    chk({nm, ".done_cycle"}, e + 1, exp_k + 1);
    chk({nm, ".flags"}, flags, exp_fl);
    tick();
    chk({nm, ".idle_after"}, {busy, done}, 2'b00);
    start = 1'b0; a = '0; b = '0; sgn = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    int           dcnt;
    int           sl;
    n_chk = 0; n_pass = 0;
    m_rem = 0; m_done = 0; m_flags = 2'b00; m_pend = 2'b00;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    tick();
    start = 1'b1; a = 32'hDEAD_BEEF;
    tick();
    chk("reset.outputs", {busy, done, flags}, 4'b0000);
    rst = 1'b0; start = 1'b0; a = '0;
    tick();

    run(32'h1234_5678, 32'h1234_5678, 1'b0, 4, 2'b00, 1'b0, "equal");
    run(32'h8000_0000, 32'h0000_0001, 1'b0, 1, 2'b01, 1'b0, "msb_u");
    run(32'h8000_0000, 32'h0000_0001, 1'b1, 1, 2'b10, 1'b0, "msb_s");
    run(32'h0000_00FE, 32'h0000_00FF, 1'b0, 4, 2'b10, 1'b0, "lsb_u");
    run(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 4, 2'b01, 1'b0, "lsb_s");
    run(32'h0000_0010, 32'h0000_0020, 1'b0, 4, 2'b10, 1'b1, "ignored_start");
    run(32'h7F00_0000, 32'h8000_0000, 1'b1, 1, 2'b01, 1'b1, "ignored_start_s");

    // Abort during the second compare cycle.
    a = 32'hCAFE_F00D; b = 32'hCAFE_F00D; sgn = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid.outputs", {busy, done, flags}, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_mid.no_done", done, 1'b0);
    end
    run(32'h0000_0100, 32'h0000_0000, 1'b0, 3, 2'b01, 1'b0, "after_rst");

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: rb = $urandom;
        1: rb = ra;
        default: begin
          rb = ra;
          sl = $urandom_range(0, NCH - 1);
          rb[sl*CHUNK +: CHUNK] = 8'($urandom);
        end
      endcase
      run(ra, rb, rs, ref_k(ra, rb), ref_flags(ra, rb, rs), 1'($urandom_range(0, 1)), "rand");
    end

    // Back-to-back with start held high and operands changing every cycle.
    dcnt = 0;
    start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      a = $urandom; b = (i % 3 == 0) ? a : $urandom; sgn = 1'($urandom_range(0, 1));
      tick();
      if (done) dcnt++;
    end
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("b2b.done_pulses_seen", dcnt > 10, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
